// File: rtl/prach_fft_bitrev_pkg.sv
// Shared PRACH types: 18-bit samples, packed complex {di,dr},
// and a bit-reversal helper used by the FFT input reorder.
package prach_fft_bitrev_pkg;

  localparam int SAMPLE_W = 18;
  localparam int BR_MAX_W = 12;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t di;
    sample_t dr;
  } cplx_t;

  // Reverses the low w bits of v (w <= BR_MAX_W).
  function automatic logic [BR_MAX_W-1:0] bitrev(
    input logic [BR_MAX_W-1:0] v,
    input int                  w
  );
    logic [BR_MAX_W-1:0] r;
    for (int i = 0; i < BR_MAX_W; i++) begin
      r[i] = v[BR_MAX_W-1-i];
    end
    return r >> (BR_MAX_W - w);
  endfunction

endpackage

// File: rtl/prach_fft_bitrev_ram.sv
// Simple dual-port ping-pong sample RAM, 2N x 36,
// synchronous read with one cycle of latency.
module prach_fft_bitrev_ram
  import prach_fft_bitrev_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cplx_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output cplx_t         rdata
);

  cplx_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prach_fft_bitrev.sv
// Natural-to-bit-reversed reorder buffer ahead of the first
// radix-2 DIT stage; output pacing mirrors the input valids.
module prach_fft_bitrev
  import prach_fft_bitrev_pkg::*;
#(
  parameter int NUM_FFT_LENGTH = 6
) (
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t din_dr,
  input  sample_t din_di,
  input  logic    din_dv,
  input  logic    sync_in,
  input  logic    din_dv_ahead,
  input  logic    sync_ahead_in,
  output sample_t dout_dr,
  output sample_t dout_di,
  output logic    dout_dv,
  output logic    sync_out,
  output logic    dout_dv_ahead,
  output logic    sync_ahead_out,
  output logic    resync_err
);

  localparam int L = NUM_FFT_LENGTH;

  logic [L-1:0] wr_cnt;
  logic         wr_bank;
  logic         rd_valid;

  logic [L-1:0] wr_idx;
  logic [L-1:0] wr_cnt_n;
  logic [L-1:0] ahd_idx;
  logic [L-1:0] ahd_rev;
  logic         wr_bank_n;
  logic         rd_valid_n;
  logic         resync;
  logic         last;
  logic         cur_ok;
  logic         ahd_ok;
  cplx_t        wr_data;
  cplx_t        ram_q;

  // The ahead side looks at post-update state: the index,
  // bank and validity the next written sample will see.
  always_comb begin
    wr_idx     = sync_in ? '0 : wr_cnt;
    resync     = din_dv & sync_in & (wr_cnt != '0);
    last       = din_dv & (&wr_idx);
    wr_cnt_n   = din_dv ? wr_idx + L'(1) : wr_cnt;
    wr_bank_n  = wr_bank ^ last;
    rd_valid_n = (rd_valid | last) & ~resync;
    cur_ok     = rd_valid & ~resync;
    ahd_idx    = sync_ahead_in ? '0 : wr_cnt_n;
    ahd_ok     = rd_valid_n
               & ~(sync_ahead_in & (wr_cnt_n != '0));
    ahd_rev    = L'(bitrev(BR_MAX_W'(ahd_idx), L));
    wr_data    = '{di: din_di, dr: din_dr};
  end

  prach_fft_bitrev_ram #(
    .AW (L + 1)
  ) u_ram (
    .clk   (clk),
    .we    (din_dv),
    .waddr ({wr_bank, wr_idx}),
    .wdata (wr_data),
    .re    (din_dv_ahead),
    .raddr ({~wr_bank_n, ahd_rev}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wr_cnt   <= wr_cnt_n;
      wr_bank  <= wr_bank_n;
      rd_valid <= rd_valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dr        <= '0;
      dout_di        <= '0;
      dout_dv        <= 1'b0;
      sync_out       <= 1'b0;
      dout_dv_ahead  <= 1'b0;
      sync_ahead_out <= 1'b0;
      resync_err     <= 1'b0;
    end else begin
      dout_dv        <= din_dv & cur_ok;
      sync_out       <= din_dv & sync_in & cur_ok;
      dout_dv_ahead  <= din_dv_ahead & ahd_ok;
      sync_ahead_out <= din_dv_ahead & sync_ahead_in
                      & ahd_ok;
      resync_err     <= resync;
      if (din_dv & cur_ok) begin
        dout_dr <= ram_q.dr;
        dout_di <= ram_q.di;
      end
    end
  end

endmodule
